// File: rtl/conv_result_streamer.sv
// Streams len results out of the convolution core's Z memory as a valid/ready/last stream.
// A 2-entry prefetch FIFO hides the 1-cycle synchronous read latency of the memory.
module conv_result_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic [ADDR_WIDTH-1:0] memZaddr_o,
    input  logic [DATA_WIDTH-1:0] memZdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [ADDR_WIDTH:0] cnt_t;

    localparam cnt_t MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam cnt_t ONE     = cnt_t'(1);

    state_t                state_q, state_d;
    cnt_t                  len_q, issued_q, sent_q;
    logic                  inflight_q;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];

    logic       pop, push, issue, last_xfer;
    logic [2:0] pending;
    cnt_t       len_clamped;

    assign len_clamped = (length_i > MAX_LEN) ? MAX_LEN : length_i;
    assign pop         = valid_o && ready_i;
    assign push        = inflight_q;
    assign last_xfer   = pop && (sent_q == len_q - ONE);
    assign pending     = 3'(count_q) + 3'(inflight_q);
    // A pop this cycle frees a slot in time for the read issued now, keeping one result per cycle.
    assign issue       = (state_q == RUN) && (issued_q < len_q) && (pending < 3'd2 + 3'(pop));

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (len_q == '0 || last_xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == RUN);
        done_o  = (state_q == DONE);
        valid_o = (count_q != 2'd0);
        data_o  = valid_o ? fifo_q[rd_ptr_q] : '0;
        last_o  = valid_o && (sent_q == len_q - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            memZaddr_o <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                len_q      <= len_clamped;
                issued_q   <= '0;
                sent_q     <= '0;
                memZaddr_o <= '0;
                inflight_q <= 1'b0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                count_q    <= 2'd0;
            end
        end else begin
            inflight_q <= issue;
            if (issue) begin
                issued_q <= issued_q + ONE;
                // Hold on the final address instead of wrapping past it.
                if (issued_q + ONE < len_q) memZaddr_o <= memZaddr_o + 1'b1;
            end
            if (pop) begin
                sent_q   <= sent_q + ONE;
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) wr_ptr_q <= ~wr_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is not reset; occupancy gates valid_o and data_o, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= memZdata_i;
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized bench for conv_result_streamer: a queue of expected Z values plus cycle-level
// expectations for busy/done/latency, checked every cycle on the falling edge.
module tb_conv_result_streamer;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst, start_i, ready_i;
    logic [AW:0]   length_i;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, data_o;
    logic          valid_o, last_o, busy_o, done_o;
    logic [DW-1:0] zmem [DEPTH];

    int    n_cmp = 0;
    int    n_err = 0;
    string cur_test = "reset";

    always #5 clk = ~clk;

    // Synchronous-read Z memory with 1-cycle latency.
    always @(posedge clk) mem_data <= zmem[mem_addr];

    conv_result_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .length_i   (length_i),
        .memZaddr_o (mem_addr),
        .memZdata_i (mem_data),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL [%s] %s: observed %0d expected %0d", cur_test, tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) zmem[i] = DW'($urandom);
    endtask

    // mode: 0 ready always high, 1 fixed 1,0,0,1,0,1,1,0 pattern, 2 random ready.
    // spam: random start pulses while the transfer is in progress.
    // abort_after: assert reset once this many transfers are done (-1 = never).
    task automatic run_xfer(input string name, input int len, input int mode,
                            input bit spam, input int abort_after);
        int            lc, lim, k, exp_done_k, n_xfer;
        int            q[$];
        int            pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;

        cur_test = name;
        lc  = (len > DEPTH) ? DEPTH : len;
        lim = (lc > 0) ? lc - 1 : 0;
        q = {};
        for (int i = 0; i < lc; i++) q.push_back(int'(zmem[i]));

        @(negedge clk);
        start_i  = 1'b1;
        length_i = (AW+1)'(len);
        ready_i  = 1'b0;
        @(posedge clk);
        #1 start_i = 1'b0;

        k = -1;
        exp_done_k = (lc == 0) ? 1 : -1;
        n_xfer = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;

        for (int guard = 0; guard < 600; guard++) begin
            @(negedge clk);
            k++;
            if (abort_after >= 0 && n_xfer == abort_after) begin
                rst = 1'b1;
                return;
            end
            case (mode)
                0:       ready_i = 1'b1;
                1:       ready_i = pat[k % 8][0];
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            start_i  = (spam && (exp_done_k < 0 || k <= exp_done_k)) ? 1'($urandom_range(0, 1)) : 1'b0;
            length_i = (AW+1)'($urandom);
            #1;

            check("done", done_o, k == exp_done_k);
            check("busy", busy_o, exp_done_k < 0 || k < exp_done_k);
            if (mode == 0 && lc > 0) check("valid_timing", valid_o, k >= 2 && k < 2 + lc);
            if (busy_o) check("addr_range", mem_addr <= lim, 1);
            if (prev_stall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, prev_data);
                check("stall_last", last_o, prev_last);
            end
            if (valid_o) begin
                if (q.size() == 0) begin
                    check("extra_valid", valid_o, 0);
                end else begin
                    check("data", data_o, q[0]);
                    check("last", last_o, q.size() == 1);
                    if (ready_i) begin
                        void'(q.pop_front());
                        n_xfer++;
                        if (q.size() == 0) exp_done_k = k + 1;
                    end
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;

            if (exp_done_k >= 0 && k == exp_done_k + 1) begin
                check("idle_valid", valid_o, 0);
                check("remaining", q.size(), 0);
                if (lc > 0) check("addr_final", mem_addr, lc - 1);
                return;
            end
        end
        check("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        ready_i = 1'b0;
        length_i = '0;
        fill_random();
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", mem_addr, 0);
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) zmem[i] = DW'(10 + i);
        run_xfer("len5", 5, 0, 1'b0, -1);

        fill_random();
        run_xfer("len8_pattern", 8, 1, 1'b0, -1);
        run_xfer("len0", 0, 0, 1'b0, -1);

        for (int i = 0; i < DEPTH; i++) zmem[i] = DW'(i * 3);
        run_xfer("len64", 64, 0, 1'b0, -1);
        run_xfer("len100_clamped", 100, 2, 1'b0, -1);

        fill_random();
        run_xfer("start_spam", 6, 2, 1'b1, -1);

        run_xfer("abort", 8, 0, 1'b0, 3);
        @(negedge clk);
        #1;
        cur_test = "after_reset";
        check("ar_addr", mem_addr, 0);
        check("ar_data", data_o, 0);
        check("ar_valid", valid_o, 0);
        check("ar_last", last_o, 0);
        check("ar_busy", busy_o, 0);
        check("ar_done", done_o, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check("ar_no_stray_valid", valid_o, 0);
        end
        fill_random();
        run_xfer("len2_after_reset", 2, 0, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_xfer("random", $urandom_range(0, 100), 2, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
